h_bit_serializer: RTL

H_BIT_SERIALIZER -- requirements
Module: h_bit_serializer

---
 rtl/h_bit_serializer.sv | 96 +++++++++
 1 files changed

// File: rtl/h_bit_serializer.sv
// LSB-first parallel-to-serial converter with a valid/ready output handshake.
// One word is in flight at a time; done pulses for one cycle after the final bit.
module h_bit_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             done_reg;
    logic             done_next;

    logic             in_shift;
    logic             at_last;
    logic             transfer;

    assign in_shift = (state_reg == SHIFT);
    assign at_last  = in_shift && (count_reg == LAST_COUNT);
    // A transfer needs out_valid, which is simply "in SHIFT".
    assign transfer = in_shift && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    shift_next = in;
                    count_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // load is deliberately not looked at here: the word in flight is protected.
                if (transfer) begin
                    shift_next = shift_reg >> 1;
                    if (at_last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, never on load or out_ready.
    assign ready     = !in_shift;
    assign out_valid = in_shift;
    assign out       = in_shift && shift_reg[0];
    assign last      = at_last;
    assign done      = done_reg;

endmodule
